word_serializer: RTL and testbench

//  Upstream sequencer for the 8-to-1 bit-select mux stage. Accepts a parallel DATA_W-bit word

---
 rtl/word_serializer_pkg.sv | 19 +
 rtl/word_serializer_if.sv | 37 +++
 rtl/word_serializer_bit_select_mux.sv | 28 ++
 rtl/word_serializer.sv | 93 +++++++++
 tb/tb_word_serializer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/word_serializer_pkg.sv
// Shared defaults and FSM encoding for the word serializer slice.
// No logic here; widths and state codes only.
// Imported by the interface, the mux and the top.
package serializer_pkg;

  // Default word width; must be a power of two and at least 2.
  localparam int DATA_W_DEF = 8;
  // Select width; must equal log2(DATA_W_DEF).
  localparam int SEL_W_DEF  = 3;
  // Width of the completed-word counter.
  localparam int CNT_W_DEF  = 8;

  // Two-state serializer FSM. IDLE waits for a word, SHIFT streams its bits.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/word_serializer_if.sv
// Handshake bundle between the serializer and its neighbours.
// Carries the parallel input side and the serial output side.
// master = environment driving words and out_ready, slave = serializer.
interface word_serializer_if
  import serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  // Parallel side. Index 0 is the first bit on the wire.
  logic [0:DATA_W-1] in_word;
  logic              in_valid;
  logic              in_ready;

  // Serial side.
  logic              out_bit;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  // Observability: live mux select and completed-word count.
  logic [SEL_W-1:0]  sel;
  logic [CNT_W-1:0]  words_done;

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_bit, out_valid, out_last, sel, words_done
  );

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_bit, out_valid, out_last, sel, words_done
  );

endinterface

// File: rtl/word_serializer_bit_select_mux.sv
// Purpose: DATA_W:1 bit-select mux, one-hot decode of sel ANDed with the word and OR-reduced.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it follows sel, which the caller holds during stalls.
module bit_select_mux
  import serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic [0:DATA_W-1] word,
  input  logic [SEL_W-1:0]  sel,
  output logic              bit_out
);

  logic [0:DATA_W-1] dec;

  // One-hot decode of sel; exactly one lane is enabled for any in-range select.
  always_comb begin
    dec = '0;
    for (int i = 0; i < DATA_W; i++) begin
      dec[i] = (sel == SEL_W'(i));
    end
  end

  // AND/OR selection keeps the mux balanced and free of priority chains.
  assign bit_out = |(dec & word);

endmodule

// File: rtl/word_serializer.sv
// Purpose: holds an accepted parallel word and streams it LSB-index-first, one bit per cycle.
// Latency: word accepted at edge N shows bit 0 in cycle N+1; DATA_W cycles per word unstalled.
// Backpressure: out_ready=0 freezes sel and held_word; in_ready only opens in IDLE or on the last-bit transfer.
module word_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  word_serializer_if.slave bus
);

  // Select value of the final bit of a word.
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(DATA_W - 1);

  state_t            state;
  logic [0:DATA_W-1] held_word;
  logic [SEL_W-1:0]  sel_q;
  logic [CNT_W-1:0]  words_done_q;

  logic              in_shift;
  logic              last_bit;
  logic              bit_xfer;
  logic              mux_bit;

  assign in_shift = (state == SHIFT);
  assign last_bit = in_shift && (sel_q == LAST_SEL);
  assign bit_xfer = in_shift && bus.out_ready;

  bit_select_mux #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_mux (
    .word    (held_word),
    .sel     (sel_q),
    .bit_out (mux_bit)
  );

  // Outputs are forced quiet while rst is asserted so nothing leaks before the
  // reset edge has been taken. in_ready looks through out_ready so a new word
  // can be taken on the same edge as the last bit leaves (no bubble).
  assign bus.in_ready   = !rst && (!in_shift || (last_bit && bus.out_ready));
  assign bus.out_valid  = !rst && in_shift;
  assign bus.out_bit    = !rst && in_shift && mux_bit;
  assign bus.out_last   = !rst && last_bit;
  assign bus.sel        = sel_q;
  assign bus.words_done = words_done_q;

  // FSM, select counter, word holding register and completed-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel_q        <= '0;
      held_word    <= '0;
      words_done_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            held_word <= bus.in_word;
            sel_q     <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_xfer) begin
            if (sel_q == LAST_SEL) begin
              // Counter wraps naturally at 2^CNT_W.
              words_done_q <= words_done_q + CNT_W'(1);
              sel_q        <= '0;
              if (bus.in_valid) begin
                // Back-to-back: next word starts on the very next cycle.
                held_word <= bus.in_word;
              end else begin
                state <= IDLE;
              end
            end else begin
              sel_q <= sel_q + SEL_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          sel_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: reset, single word, back-to-back, stall,
// mid-word reset and counter wrap. Inputs change 1 time unit after the rising
// edge; outputs are sampled 2 time units after it.
module tb_word_serializer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  word_serializer_if #(.DATA_W(8), .SEL_W(3), .CNT_W(8)) bus ();

  word_serializer #(.DATA_W(8), .SEL_W(3), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed bit streams (in_word[0] first, word declared [0:7]).
  int seq2 [8]  = '{1, 0, 1, 1, 0, 0, 1, 0};                          // 8'b1011_0010
  int seq3 [16] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1, 0, 0};  // 8'hA5, 8'h3C
  int sel4 [11] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6, 7};                 // stall at sel=4
  int bit4 [11] = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0};                 // 8'h96 under stall

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:7] wv(input int k);
    return 8'(k * 37 + 11);
  endfunction

  initial begin
    logic [0:7] wk;
    checks   = 0;
    failures = 0;

    // ---- 1. Reset held 2 cycles with in_valid high ----
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_word   = 8'h00;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready",   bus.in_ready,   0);
    chk("rst_out_valid",  bus.out_valid,  0);
    chk("rst_out_bit",    bus.out_bit,    0);
    chk("rst_out_last",   bus.out_last,   0);
    chk("rst_sel",        bus.sel,        0);
    chk("rst_words_done", bus.words_done, 0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rel_in_ready",  bus.in_ready,  1);
    chk("rel_out_valid", bus.out_valid, 0);

    // ---- 2. Single word 8'b1011_0010 ----
    bus.in_word  = 8'b1011_0010;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_word  = 8'h00;  // must not disturb the held word
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_valid", bus.out_valid, 1);
      chk("t2_bit",   bus.out_bit,   seq2[i]);
      chk("t2_last",  bus.out_last,  (i == 7));
      chk("t2_sel",   bus.sel,       i);
      chk("t2_ready", bus.in_ready,  (i == 7));
      tick();
    end
    #1;
    chk("t2_idle_valid", bus.out_valid,  0);
    chk("t2_idle_ready", bus.in_ready,   1);
    chk("t2_words_done", bus.words_done, 1);

    // ---- 3. Back-to-back 8'hA5 then 8'h3C (words_done cumulative) ----
    bus.in_word  = 8'hA5;
    bus.in_valid = 1'b1;
    tick();
    bus.in_word = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("t3_valid", bus.out_valid, 1);
      chk("t3_bit",   bus.out_bit,   seq3[i]);
      chk("t3_last",  bus.out_last,  (i == 7 || i == 15));
      chk("t3_ready", bus.in_ready,  (i == 7 || i == 15));
      if (i == 8) chk("t3_words_mid", bus.words_done, 2);
      if (i == 15) bus.in_valid = 1'b0;
      tick();
    end
    #1;
    chk("t3_idle_valid", bus.out_valid,  0);
    chk("t3_words_done", bus.words_done, 3);

    // ---- 4. Stall three cycles at sel=4, word 8'h96 ----
    bus.in_word  = 8'h96;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      bus.out_ready = !(c >= 4 && c <= 6);
      #1;
      chk("t4_valid", bus.out_valid, 1);
      chk("t4_sel",   bus.sel,       sel4[c]);
      chk("t4_bit",   bus.out_bit,   bit4[c]);
      chk("t4_last",  bus.out_last,  (c == 10));
      chk("t4_ready", bus.in_ready,  (c == 10));
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t4_idle_valid", bus.out_valid,  0);
    chk("t4_words_done", bus.words_done, 4);

    // ---- 5. Reset in the middle of a word at sel=5 ----
    bus.in_word  = 8'h0F;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("t5_sel_before", bus.sel,     5);
    chk("t5_bit_before", bus.out_bit, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", bus.out_valid, 0);
    chk("t5_rst_bit",   bus.out_bit,   0);
    chk("t5_rst_last",  bus.out_last,  0);
    chk("t5_rst_ready", bus.in_ready,  0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_sel",        bus.sel,        0);
    chk("t5_words_done", bus.words_done, 0);
    chk("t5_out_valid",  bus.out_valid,  0);
    chk("t5_in_ready",   bus.in_ready,   1);
    bus.in_word  = 8'hFF;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t5_ff_bit", bus.out_bit, 1);
      chk("t5_ff_sel", bus.sel,     i);
      tick();
    end
    #1;
    chk("t5_ff_words", bus.words_done, 1);

    // ---- 6. 256 streamed words: counter wrap, in_word scrambled during SHIFT ----
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_word  = wv(0);
    bus.in_valid = 1'b1;
    tick();
    for (int k = 0; k < 256; k++) begin
      wk = wv(k);
      for (int b = 0; b < 8; b++) begin
        bus.in_valid = (k != 255);
        bus.in_word  = (b == 7) ? wv(k + 1) : 8'($urandom);
        #1;
        chk("t6_valid", bus.out_valid, 1);
        chk("t6_bit",   bus.out_bit,   wk[b]);
        chk("t6_sel",   bus.sel,       b);
        if (k == 255 && b == 0) chk("t6_words_255", bus.words_done, 255);
        tick();
      end
    end
    bus.in_valid = 1'b0;
    #1;
    chk("t6_wrap_words", bus.words_done, 0);
    chk("t6_idle_valid", bus.out_valid,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
